judge_features_vote: RTL and testbench

//  Frame-level fruit classifier, parametrised successor of the fixed 11-score judge stage. Selects a shape band from
//  the area and shape factor, then runs a serial argmax over the band's candidate scores, with tie detection. Each new

---
 rtl/judge_pkg.sv | 29 ++
 rtl/judge_argmax_scan.sv | 84 ++++++++
 rtl/judge_features_vote.sv | 256 +++++++++++++++++++++++++
 tb/tb_judge_features_vote.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/judge_pkg.sv
// Shared definitions for the frame judge: class codes, FSM states and a
// reference shape-band table used by the judge and its bench.
package judge_pkg;

  localparam int CLASS_NONE  = 0;
  localparam int CLASS_SMALL = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_SCAN,
    ST_VOTE
  } judge_state_e;

  // Reference table for four bands, band 0 in the low bits.
  // Band 2 has lo > hi and therefore never matches.
  localparam int          DEF_NB           = 4;
  localparam logic [31:0] DEF_BAND_LO      = {8'h50, 8'h40, 8'h20, 8'h10};
  localparam logic [31:0] DEF_BAND_HI      = {8'h5F, 8'h3F, 8'h2F, 8'h12};
  localparam logic [31:0] DEF_BAND_MASK    = {8'hFF, 8'hFF, 8'hF0, 8'h0F};
  localparam logic [15:0] DEF_BAND_DEFAULT = {4'd7, 4'd1, 4'd5, 4'd3};

  function automatic logic band_hit(input logic [7:0] lo,
                                    input logic [7:0] hi,
                                    input logic [7:0] v);
    return (lo <= v) && (v <= hi);
  endfunction

endpackage

// File: rtl/judge_argmax_scan.sv
// Serial argmax over N scores, one index per cycle, with tie and empty flags.
// Result outputs already include the index being examined in the done cycle.
module judge_argmax_scan
  import judge_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 24
) (
  input  logic                 pixelclk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N-1:0]         mask,
  input  logic [N*SW-1:0]      scores,
  output logic                 done,
  output logic [$clog2(N)-1:0] best_idx,
  output logic                 tie,
  output logic                 empty
);

  localparam int             IW   = $clog2(N);
  localparam logic [IW-1:0]  LAST = IW'(N - 1);

  logic          active_q, active_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] bidx_q, bidx_d;
  logic [SW-1:0] best_q, best_d;
  logic          tie_q, tie_d;
  logic          have_q, have_d;
  logic [SW-1:0] cur;

  always_comb begin
    cur      = scores[idx_q*SW +: SW];
    active_d = active_q;
    idx_d    = idx_q;
    bidx_d   = bidx_q;
    best_d   = best_q;
    tie_d    = tie_q;
    have_d   = have_q;
    if (active_q && mask[idx_q]) begin
      if (!have_q || (cur > best_q)) begin
        best_d = cur;
        bidx_d = idx_q;
        tie_d  = 1'b0;
        have_d = 1'b1;
      end else if (cur == best_q) begin
        tie_d = 1'b1;
      end
    end
    if (active_q) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST) active_d = 1'b0;
    end
    if (start) begin
      active_d = 1'b1;
      idx_d    = '0;
      have_d   = 1'b0;
      tie_d    = 1'b0;
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      bidx_q   <= '0;
      best_q   <= '0;
      tie_q    <= 1'b0;
      have_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      bidx_q   <= bidx_d;
      best_q   <= best_d;
      tie_q    <= tie_d;
      have_q   <= have_d;
    end
  end

  assign done     = active_q && (idx_q == LAST);
  assign best_idx = bidx_d;
  assign tie      = tie_d;
  assign empty    = !have_d;

endmodule

// File: rtl/judge_features_vote.sv
// Frame-level fruit classifier: band select, serial argmax, and a vote filter
// that only changes the reported class after VOTE_N identical frame results.
//
// state   | meaning
// IDLE    | waiting for a frame-end trigger
// PRE     | area thresholds and shape band lookup
// SCAN    | argmax over the band's candidate scores (N cycles)
// VOTE    | publish frame result, update vote counter and sort
module judge_features_vote
  import judge_pkg::*;
#(
  parameter int N      = 8,
  parameter int SW     = 24,
  parameter int CW     = 4,
  parameter int NB     = 4,
  parameter int VOTE_N = 3
) (
  input  logic              pixelclk,
  input  logic              reset_n,
  input  logic [23:0]       i_rgb,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_de,
  input  logic [15:0]       area,
  input  logic [7:0]        shape,
  input  logic [N*SW-1:0]   scores,
  input  logic [15:0]       cfg_area_min,
  input  logic [15:0]       cfg_area_small,
  input  logic [NB*8-1:0]   band_lo,
  input  logic [NB*8-1:0]   band_hi,
  input  logic [NB*N-1:0]   band_mask,
  input  logic [NB*CW-1:0]  band_default,
  input  logic [N*CW-1:0]   class_map,
  output logic [23:0]       o_rgb,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [CW-1:0]     sort,
  output logic              sort_valid,
  output logic [CW-1:0]     raw_class,
  output logic              busy,
  output logic              overrun
);

  localparam int IW = $clog2(N);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int VW = $clog2(VOTE_N + 1);

  // Pixel stream pass-through, intentionally outside the reset domain.
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vso_q, vso_d, de_q, de_d;

  always_comb begin
    rgb_d = i_rgb;
    hs_d  = i_hsync;
    vso_d = i_vsync;
    de_d  = i_de;
  end

  always_ff @(posedge pixelclk) begin
    rgb_q <= rgb_d;
    hs_q  <= hs_d;
    vso_q <= vso_d;
    de_q  <= de_d;
  end

  assign o_rgb   = rgb_q;
  assign o_hsync = hs_q;
  assign o_vsync = vso_q;
  assign o_de    = de_q;

  judge_state_e       state_q, state_d;
  logic               vs_q, vs_d, trig_q, trig_d;
  logic               busy_q, busy_d, overrun_q, overrun_d;
  logic [15:0]        area_q, area_d, amin_q, amin_d, asmall_q, asmall_d;
  logic [7:0]         shape_q, shape_d;
  logic [N*SW-1:0]    scores_q, scores_d;
  logic [NB*8-1:0]    lo_q, lo_d, hi_q, hi_d;
  logic [NB*N-1:0]    mask_q, mask_d;
  logic [NB*CW-1:0]   dflt_q, dflt_d;
  logic [N*CW-1:0]    cmap_q, cmap_d;
  logic [BW-1:0]      band_q, band_d;
  logic [CW-1:0]      res_q, res_d, raw_class_q, raw_class_d;
  logic [CW-1:0]      cand_q, cand_d, sort_q, sort_d;
  logic [VW-1:0]      cnt_q, cnt_d;
  logic               sort_valid_q, sort_valid_d;

  logic               hit_any;
  logic [BW-1:0]      hit_b;
  logic               scan_start, scan_done, scan_tie, scan_empty;
  logic [IW-1:0]      scan_idx;

  // Lowest-numbered matching band wins.
  always_comb begin
    hit_any = 1'b0;
    hit_b   = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (band_hit(lo_q[b*8 +: 8], hi_q[b*8 +: 8], shape_q)) begin
        hit_any = 1'b1;
        hit_b   = BW'(b);
      end
    end
  end

  judge_argmax_scan #(.N(N), .SW(SW)) u_scan (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .start    (scan_start),
    .mask     (mask_q[band_q*N +: N]),
    .scores   (scores_q),
    .done     (scan_done),
    .best_idx (scan_idx),
    .tie      (scan_tie),
    .empty    (scan_empty)
  );

  always_comb begin
    vs_d         = i_vsync;
    trig_d       = i_vsync & ~vs_q;
    state_d      = state_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q | (trig_q & (state_q != ST_IDLE));
    area_d       = area_q;
    shape_d      = shape_q;
    scores_d     = scores_q;
    amin_d       = amin_q;
    asmall_d     = asmall_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    mask_d       = mask_q;
    dflt_d       = dflt_q;
    cmap_d       = cmap_q;
    band_d       = band_q;
    res_d        = res_q;
    raw_class_d  = raw_class_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    sort_d       = sort_q;
    sort_valid_d = 1'b0;
    scan_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_q) begin
          area_d   = area;
          shape_d  = shape;
          scores_d = scores;
          amin_d   = cfg_area_min;
          asmall_d = cfg_area_small;
          lo_d     = band_lo;
          hi_d     = band_hi;
          mask_d   = band_mask;
          dflt_d   = band_default;
          cmap_d   = class_map;
          busy_d   = 1'b1;
          state_d  = ST_PRE;
        end
      end
      ST_PRE: begin
        if (area_q <= amin_q) begin
          res_d   = CW'(CLASS_NONE);
          state_d = ST_VOTE;
        end else if (area_q <= asmall_q) begin
          res_d   = CW'(CLASS_SMALL);
          state_d = ST_VOTE;
        end else if (hit_any) begin
          band_d     = hit_b;
          scan_start = 1'b1;
          state_d    = ST_SCAN;
        end else begin
          res_d   = raw_class_q;
          state_d = ST_VOTE;
        end
      end
      ST_SCAN: begin
        if (scan_done) begin
          res_d   = (scan_tie || scan_empty) ? dflt_q[band_q*CW +: CW]
                                             : cmap_q[scan_idx*CW +: CW];
          state_d = ST_VOTE;
        end
      end
      ST_VOTE: begin
        raw_class_d = res_q;
        if (res_q == cand_q) begin
          if (cnt_q != VW'(VOTE_N)) cnt_d = cnt_q + 1'b1;
        end else begin
          cand_d = res_q;
          cnt_d  = VW'(1);
        end
        if ((cnt_d == VW'(VOTE_N)) && (cand_d != sort_q)) begin
          sort_d       = cand_d;
          sort_valid_d = 1'b1;
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      area_q       <= '0;
      shape_q      <= '0;
      scores_q     <= '0;
      amin_q       <= '0;
      asmall_q     <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      mask_q       <= '0;
      dflt_q       <= '0;
      cmap_q       <= '0;
      band_q       <= '0;
      res_q        <= '0;
      raw_class_q  <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      sort_q       <= '0;
      sort_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_d;
      trig_q       <= trig_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      area_q       <= area_d;
      shape_q      <= shape_d;
      scores_q     <= scores_d;
      amin_q       <= amin_d;
      asmall_q     <= asmall_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      mask_q       <= mask_d;
      dflt_q       <= dflt_d;
      cmap_q       <= cmap_d;
      band_q       <= band_d;
      res_q        <= res_d;
      raw_class_q  <= raw_class_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      sort_q       <= sort_d;
      sort_valid_q <= sort_valid_d;
    end
  end

  assign sort       = sort_q;
  assign sort_valid = sort_valid_q;
  assign raw_class  = raw_class_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_judge_features_vote.sv
// Directed bench for judge_features_vote: a frame-level reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_judge_features_vote;
  import judge_pkg::*;

  localparam int N = 8, SW = 24, CW = 4, NB = 4, VOTE_N = 3;
  localparam int LAT_SCAN = N + 3, LAT_FAST = 3;

  logic pixelclk = 1'b0;
  logic reset_n  = 1'b0;
  logic [23:0] i_rgb = '0;
  logic i_hsync = 1'b0, vsync = 1'b0, i_de = 1'b0;
  logic [15:0] area = '0, amin = 16'h0020, asmall = 16'h0040;
  logic [7:0]  shape = '0;

  logic [SW-1:0] sc [N];
  logic [CW-1:0] cm [N];
  logic [7:0]    blo [NB];
  logic [7:0]    bhi [NB];
  logic [N-1:0]  bmask [NB];
  logic [CW-1:0] bdef [NB];

  logic [N*SW-1:0]  scores_p;
  logic [NB*8-1:0]  lo_p, hi_p;
  logic [NB*N-1:0]  mask_p;
  logic [NB*CW-1:0] def_p;
  logic [N*CW-1:0]  cmap_p;

  logic [23:0]   o_rgb;
  logic          o_hsync, o_vsync, o_de, sort_valid, busy, overrun;
  logic [CW-1:0] sort, raw_class;

  always_comb begin
    scores_p = '0;
    cmap_p   = '0;
    lo_p     = '0;
    hi_p     = '0;
    mask_p   = '0;
    def_p    = '0;
    for (int k = 0; k < N; k++) begin
      scores_p[k*SW +: SW] = sc[k];
      cmap_p[k*CW +: CW]   = cm[k];
    end
    for (int b = 0; b < NB; b++) begin
      lo_p[b*8 +: 8]     = blo[b];
      hi_p[b*8 +: 8]     = bhi[b];
      mask_p[b*N +: N]   = bmask[b];
      def_p[b*CW +: CW]  = bdef[b];
    end
  end

  judge_features_vote #(.N(N), .SW(SW), .CW(CW), .NB(NB), .VOTE_N(VOTE_N)) dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_rgb(i_rgb), .i_hsync(i_hsync),
    .i_vsync(vsync), .i_de(i_de), .area(area), .shape(shape), .scores(scores_p),
    .cfg_area_min(amin), .cfg_area_small(asmall), .band_lo(lo_p), .band_hi(hi_p),
    .band_mask(mask_p), .band_default(def_p), .class_map(cmap_p),
    .o_rgb(o_rgb), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .sort(sort), .sort_valid(sort_valid), .raw_class(raw_class), .busy(busy),
    .overrun(overrun)
  );

  always #5 pixelclk = ~pixelclk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Frame result from the classification rules directly.
  function automatic logic [CW-1:0] model_raw(input logic [CW-1:0] hold, output bit scan);
    scan = 1'b0;
    if (area <= amin) return CW'(CLASS_NONE);
    if (area <= asmall) return CW'(CLASS_SMALL);
    for (int b = 0; b < NB; b++) begin
      if (blo[b] <= shape && shape <= bhi[b]) begin
        longint mx = -1;
        int arg = 0, nmax = 0;
        scan = 1'b1;
        for (int k = 0; k < N; k++)
          if (bmask[b][k] && longint'(sc[k]) > mx) begin mx = longint'(sc[k]); arg = k; end
        for (int k = 0; k < N; k++)
          if (bmask[b][k] && longint'(sc[k]) == mx) nmax++;
        return (nmax == 1) ? cm[arg] : bdef[b];
      end
    end
    return hold;
  endfunction

  int            e = 0, done_e = 0, m_cnt = 0;
  bit            inflight = 0, vs_prev = 0, trig_pend = 0, m_sv = 0, m_ovr = 0;
  logic [CW-1:0] m_sort = '0, m_raw = '0, m_cand = '0, m_res = '0;

  always @(posedge pixelclk or negedge reset_n) begin
    bit trig, was, scan_path;
    if (!reset_n) begin
      inflight = 0; vs_prev = 0; trig_pend = 0; m_sv = 0; m_ovr = 0;
      m_sort = '0; m_raw = '0; m_cand = '0; m_cnt = 0;
    end else begin
      e++;
      m_sv      = 0;
      trig      = trig_pend;
      trig_pend = vsync && !vs_prev;
      vs_prev   = vsync;
      was       = inflight;
      if (trig && was) m_ovr = 1;
      if (was && e == done_e) begin
        if (m_res == m_cand) begin
          if (m_cnt < VOTE_N) m_cnt++;
        end else begin
          m_cand = m_res;
          m_cnt  = 1;
        end
        m_raw = m_res;
        if (m_cnt == VOTE_N && m_cand != m_sort) begin
          m_sort = m_cand;
          m_sv   = 1;
        end
        inflight = 0;
      end
      if (trig && !was) begin
        m_res    = model_raw(m_raw, scan_path);
        done_e   = e + (scan_path ? N + 2 : 2);
        inflight = 1;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge pixelclk) begin
    if (cmp_en && reset_n) begin
      chk("cyc_sort", int'(sort), int'(m_sort));
      chk("cyc_sort_valid", int'(sort_valid), int'(m_sv));
      chk("cyc_raw_class", int'(raw_class), int'(m_raw));
      chk("cyc_busy", int'(busy), int'(inflight));
      chk("cyc_overrun", int'(overrun), int'(m_ovr));
    end
  end

  // Drive one trigger; check sort_valid one cycle before and at the expected latency.
  task automatic frame(input string nm, input int lat, input bit pulse);
    @(posedge pixelclk); #2 vsync = 1'b1;
    @(posedge pixelclk); #2 vsync = 1'b0;
    repeat (lat - 1) @(posedge pixelclk);
    @(negedge pixelclk); chk({nm, "_sv_early"}, int'(sort_valid), 0);
    @(posedge pixelclk);
    @(negedge pixelclk); chk({nm, "_sv"}, int'(sort_valid), int'(pulse));
    repeat (3) @(posedge pixelclk);
  endtask

  task automatic set_band0_scores(input bit tie_set);
    logic [SW-1:0] v [N];
    v = '{24'd5, 24'd9, 24'd7, 24'd2, 24'd1, 24'd20, 24'd3, 24'd4};
    if (tie_set) begin v[0] = 24'd9; v[2] = 24'd1; v[3] = 24'd1; end
    for (int k = 0; k < N; k++) sc[k] = v[k];
  endtask

  initial begin
    logic [31:0] tlo, thi, tmask;
    logic [15:0] tdef;
    logic [CW-1:0] cmv [N];
    tlo = DEF_BAND_LO; thi = DEF_BAND_HI; tmask = DEF_BAND_MASK; tdef = DEF_BAND_DEFAULT;
    for (int b = 0; b < NB; b++) begin
      blo[b]   = tlo[b*8 +: 8];
      bhi[b]   = thi[b*8 +: 8];
      bmask[b] = tmask[b*8 +: 8];
      bdef[b]  = tdef[b*4 +: 4];
    end
    cmv = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd8, 4'd9};
    for (int k = 0; k < N; k++) cm[k] = cmv[k];
    set_band0_scores(0);

    repeat (3) @(posedge pixelclk);
    #2 reset_n = 1'b1;
    @(negedge pixelclk);
    chk("rst_sort", int'(sort), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sort_valid", int'(sort_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_raw", int'(raw_class), 0);
    cmp_en = 1;

    // No object: raw 0, sort already 0 so no pulse.
    area = 16'h0010;
    frame("no_obj", LAT_FAST, 0);
    chk("no_obj_raw", int'(raw_class), 0);

    // Band 0 argmax: k=1 wins, class 2 after three frames.
    area = 16'h0100; shape = 8'h11;
    frame("b0_f1", LAT_SCAN, 0);
    chk("b0_f1_raw", int'(raw_class), 2);
    frame("b0_f2", LAT_SCAN, 0);
    frame("b0_f3", LAT_SCAN, 1);
    chk("b0_sort", int'(sort), 2);

    // Tie and empty mask fall back to the band default.
    set_band0_scores(1);
    frame("tie", LAT_SCAN, 0);
    chk("tie_raw", int'(raw_class), 3);
    set_band0_scores(0);
    bmask[0] = '0;
    frame("empty", LAT_SCAN, 0);
    chk("empty_raw", int'(raw_class), 3);
    bmask[0] = 8'h0F;

    // Alternating results never settle; three 4s in a row do.
    for (int i = 0; i < 5; i++) begin
      shape = (i % 2 == 0) ? 8'h11 : 8'h25;
      frame("alt", LAT_SCAN, 0);
      chk("alt_raw", int'(raw_class), (i % 2 == 0) ? 2 : 4);
    end
    chk("alt_sort", int'(sort), 2);
    shape = 8'h25;
    frame("four_1", LAT_SCAN, 0);
    frame("four_2", LAT_SCAN, 0);
    frame("four_3", LAT_SCAN, 1);
    chk("four_sort", int'(sort), 4);

    // Second edge four cycles after the first, mid-scan.
    shape = 8'h11;
    @(posedge pixelclk); #2 vsync = 1'b1;
    @(posedge pixelclk); #2 vsync = 1'b0;
    repeat (3) @(posedge pixelclk); #2 vsync = 1'b1;
    @(posedge pixelclk); #2 vsync = 1'b0;
    repeat (LAT_SCAN + 2) @(posedge pixelclk);
    @(negedge pixelclk);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_raw", int'(raw_class), 2);
    chk("ovr_idle", int'(busy), 0);

    // Shape 0x40 only falls in the inverted band: no match, raw holds.
    shape = 8'h40;
    frame("hold", LAT_FAST, 0);
    chk("hold_raw", int'(raw_class), 2);

    // Reset while the scan is examining k=3.
    shape = 8'h11;
    @(posedge pixelclk); #2 vsync = 1'b1;
    @(posedge pixelclk); #2 vsync = 1'b0;
    repeat (5) @(posedge pixelclk); #2 reset_n = 1'b0;
    @(negedge pixelclk);
    chk("abort_sort", int'(sort), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sv", int'(sort_valid), 0);
    chk("abort_ovr", int'(overrun), 0);
    repeat (2) @(posedge pixelclk); #2 reset_n = 1'b1;
    repeat (2) @(posedge pixelclk);
    #2 vsync = 1'b1;
    @(posedge pixelclk); #2 vsync = 1'b0;
    repeat (N + 2) @(posedge pixelclk);
    @(negedge pixelclk); chk("fresh_busy_last", int'(busy), 1);
    @(posedge pixelclk);
    @(negedge pixelclk); chk("fresh_busy_done", int'(busy), 0);
    chk("fresh_raw", int'(raw_class), 2);
    repeat (3) @(posedge pixelclk);

    // Small object.
    area = 16'h0030;
    frame("small", LAT_FAST, 0);
    chk("small_raw", int'(raw_class), 6);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
